// File: rtl/busctl_pkg.sv
// ============================================================================
// busctl_pkg: shared region/state types and address decode for busctl.
// Rev 1.0
// ============================================================================
`default_nettype none

package busctl_pkg;

  localparam logic [3:0]  DRAM_TOP_NIBBLE = 4'h0;
  localparam logic [11:0] ROM_BASE        = 12'hFFF;
  localparam logic [11:0] IO_BASE         = 12'hFFE;
  localparam logic [2:0]  FC_CPU_SPACE    = 3'b111;

  typedef enum logic [1:0] {NONE, DRAM, ROM, IO} region_e;
  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_e;

  // Low memory is shadowed by ROM until the first real ROM access clears the overlay.
  function automatic region_e decode(input logic [11:0] addr, input logic overlay);
    region_e r;
    r = NONE;
    if (addr == ROM_BASE)                   r = ROM;
    else if (addr == IO_BASE)               r = IO;
    else if (addr[11:8] == DRAM_TOP_NIBBLE) r = overlay ? ROM : DRAM;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/busctl_watchdog.sv
// ============================================================================
// bus_watchdog: raises BERR when an active bus cycle goes unacknowledged.
// Rev 1.0
// ============================================================================
`default_nettype none

module bus_watchdog #(
  parameter int TIMEOUT_CNT = 250
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  input  logic ack,
  output logic BERR
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CNT);

  logic [7:0] cnt_q, cnt_d;
  logic       acked_q, acked_d;
  logic       berr_q, berr_d;

  always_comb begin
    cnt_d   = cnt_q;
    acked_d = acked_q;
    berr_d  = berr_q;
    if (!active) begin
      cnt_d   = 8'd0;
      acked_d = 1'b0;
      berr_d  = 1'b0;
    end else if (ack || acked_q) begin
      // An acknowledge freezes the count for the rest of the cycle and beats a coincident timeout.
      acked_d = 1'b1;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == LIMIT) berr_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= 8'd0;
      acked_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acked_q <= acked_d;
      berr_q  <= berr_d;
    end
  end

  assign BERR = berr_q;

endmodule

`default_nettype wire

// File: rtl/busctl.sv
// ============================================================================
// busctl: 68030 bus decode, ROM/IO wait-state termination, reset ROM overlay.
// Rev 1.0
// ============================================================================
`default_nettype none

module busctl
  import busctl_pkg::*;
#(
  parameter int ROM_WS      = 3,
  parameter int IO_WS       = 6,
  parameter int TIMEOUT_CNT = 250
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        nAS,
  input  logic [2:0]  FC,
  input  logic [11:0] ADDR,
  input  logic        EXT_ACK,
  output logic        DRAM_nCS,
  output logic        ROM_nCS,
  output logic        IO_nCS,
  output logic        DSACK0,
  output logic        DSACK1,
  output logic        BERR,
  output logic        OVERLAY
);

  state_e     state_q, state_d;
  region_e    region_q, region_d;
  logic [3:0] wait_q, wait_d;
  logic       native_rom_q, native_rom_d;
  logic       overlay_q, overlay_d;
  logic       dram_ncs_q, dram_ncs_d;
  logic       rom_ncs_q, rom_ncs_d;
  logic       io_ncs_q, io_ncs_d;
  logic       dsack0_q, dsack0_d;
  logic       dsack1_q, dsack1_d;

  always_comb begin
    state_d      = state_q;
    region_d     = region_q;
    wait_d       = wait_q;
    native_rom_d = native_rom_q;
    overlay_d    = overlay_q;
    dram_ncs_d   = dram_ncs_q;
    rom_ncs_d    = rom_ncs_q;
    io_ncs_d     = io_ncs_q;
    dsack0_d     = dsack0_q;
    dsack1_d     = dsack1_q;
    case (state_q)
      IDLE: begin
        if (!nAS && FC != FC_CPU_SPACE) begin
          region_d     = decode(ADDR, overlay_q);
          native_rom_d = (ADDR == ROM_BASE);
          dram_ncs_d   = (region_d != DRAM);
          rom_ncs_d    = (region_d != ROM);
          io_ncs_d     = (region_d != IO);
          case (region_d)
            ROM:     begin wait_d = 4'(ROM_WS); state_d = WAIT; end
            IO:      begin wait_d = 4'(IO_WS);  state_d = WAIT; end
            default: state_d = HOLD;
          endcase
        end
      end
      default: begin
        if (nAS) begin
          state_d    = IDLE;
          dram_ncs_d = 1'b1;
          rom_ncs_d  = 1'b1;
          io_ncs_d   = 1'b1;
          dsack0_d   = 1'b0;
          dsack1_d   = 1'b0;
          if (native_rom_q) overlay_d = 1'b0;
        end else if (state_q == WAIT) begin
          if (wait_q == 4'd0) begin
            dsack1_d = (region_q == ROM);
            dsack0_d = (region_q == IO);
            state_d  = ACK;
          end else begin
            wait_d = wait_q - 4'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      region_q     <= NONE;
      wait_q       <= 4'd0;
      native_rom_q <= 1'b0;
      overlay_q    <= 1'b1;
      dram_ncs_q   <= 1'b1;
      rom_ncs_q    <= 1'b1;
      io_ncs_q     <= 1'b1;
      dsack0_q     <= 1'b0;
      dsack1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      region_q     <= region_d;
      wait_q       <= wait_d;
      native_rom_q <= native_rom_d;
      overlay_q    <= overlay_d;
      dram_ncs_q   <= dram_ncs_d;
      rom_ncs_q    <= rom_ncs_d;
      io_ncs_q     <= io_ncs_d;
      dsack0_q     <= dsack0_d;
      dsack1_q     <= dsack1_d;
    end
  end

  // Watchdog drops out on the same edge that samples nAS high, so BERR releases with the selects.
  bus_watchdog #(
    .TIMEOUT_CNT (TIMEOUT_CNT)
  ) u_watchdog (
    .CLK    (CLK),
    .RST    (RST),
    .active ((state_q != IDLE) && !nAS),
    .ack    (EXT_ACK || dsack0_q || dsack1_q),
    .BERR   (BERR)
  );

  assign DRAM_nCS = dram_ncs_q;
  assign ROM_nCS  = rom_ncs_q;
  assign IO_nCS   = io_ncs_q;
  assign DSACK0   = dsack0_q;
  assign DSACK1   = dsack1_q;
  assign OVERLAY  = overlay_q;

endmodule

`default_nettype wire

// File: tb/tb_busctl.sv
// ============================================================================
// tb_busctl: directed checks of busctl decode, wait states, overlay, watchdog.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_busctl;

  logic        clk = 1'b0;
  logic        rst, nas, ext_ack;
  logic [2:0]  fc;
  logic [11:0] addr;
  logic        dram_ncs, rom_ncs, io_ncs, dsack0, dsack1, berr, overlay;
  int          n_pass  = 0;
  int          n_total = 0;

  always #20 clk = ~clk;

  busctl dut (
    .CLK      (clk),
    .RST      (rst),
    .nAS      (nas),
    .FC       (fc),
    .ADDR     (addr),
    .EXT_ACK  (ext_ack),
    .DRAM_nCS (dram_ncs),
    .ROM_nCS  (rom_ncs),
    .IO_nCS   (io_ncs),
    .DSACK0   (dsack0),
    .DSACK1   (dsack1),
    .BERR     (berr),
    .OVERLAY  (overlay)
  );

  // Bit order: DRAM_nCS ROM_nCS IO_nCS DSACK1 DSACK0 BERR OVERLAY
  logic [6:0] outs;
  assign outs = {dram_ncs, rom_ncs, io_ncs, dsack1, dsack0, berr, overlay};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    n_total++;
    assert (outs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, outs, exp);
  endtask

  initial begin
    rst = 1'b1; nas = 1'b1; fc = 3'd5; addr = 12'h000; ext_ack = 1'b0;
    step(2);
    rst = 1'b0;
    chk("reset", 7'b1110001);

    // Reset fetch at 0 goes to ROM under overlay
    nas = 1'b0; addr = 12'h000;
    step(1); chk("ovl_rom_sel", 7'b1010001);
    step(3); chk("ovl_rom_wait", 7'b1010001);
    step(1); chk("ovl_rom_dsack", 7'b1011001);
    nas = 1'b1;
    step(1); chk("ovl_rom_release", 7'b1110001);

    // Native ROM read clears the overlay at cycle end
    nas = 1'b0; addr = 12'hFFF;
    step(1); chk("rom_sel", 7'b1010001);
    step(4); chk("rom_dsack", 7'b1011001);
    nas = 1'b1;
    step(1); chk("ovl_clear", 7'b1110000);

    // DRAM at 0 now, acked externally at edge 5
    nas = 1'b0; addr = 12'h000;
    step(1); chk("dram_sel", 7'b0110000);
    step(4); chk("dram_no_dsack", 7'b0110000);
    ext_ack = 1'b1;
    step(1);
    ext_ack = 1'b0;
    step(300); chk("dram_acked_no_berr", 7'b0110000);
    nas = 1'b1;
    step(1); chk("dram_release", 7'b1110000);

    // I/O 8-bit port
    nas = 1'b0; addr = 12'hFFE;
    step(1); chk("io_sel", 7'b1100000);
    step(6); chk("io_wait", 7'b1100000);
    step(1); chk("io_dsack", 7'b1100100);
    nas = 1'b1;
    step(1); chk("io_release", 7'b1110000);

    // Unmapped: watchdog timeout
    nas = 1'b0; addr = 12'h400;
    step(1);   chk("unmapped_nosel", 7'b1110000);
    step(249); chk("unmapped_pre_berr", 7'b1110000);
    step(1);   chk("unmapped_berr", 7'b1110010);
    step(3);   chk("unmapped_berr_hold", 7'b1110010);
    nas = 1'b1;
    step(1);   chk("unmapped_release", 7'b1110000);

    // CPU space is ignored
    nas = 1'b0; fc = 3'd7; addr = 12'hFFF;
    step(3); chk("cpu_space", 7'b1110000);
    nas = 1'b1; fc = 3'd5;
    step(1); chk("cpu_space_end", 7'b1110000);

    // Ack on the timeout edge wins
    nas = 1'b0; addr = 12'h000;
    step(1);   chk("race_sel", 7'b0110000);
    step(249); chk("race_pre", 7'b0110000);
    ext_ack = 1'b1;
    step(1);   chk("race_ack_wins", 7'b0110000);
    ext_ack = 1'b0;
    step(5);   chk("race_no_late_berr", 7'b0110000);
    nas = 1'b1;
    step(1);   chk("race_release", 7'b1110000);

    // Reset during WAIT
    nas = 1'b0; addr = 12'hFFE;
    step(1); chk("rstwait_sel", 7'b1100000);
    step(2);
    rst = 1'b1;
    step(1); chk("rstwait_reset", 7'b1110001);
    rst = 1'b0; nas = 1'b1;
    step(1); chk("rstwait_idle", 7'b1110001);
    nas = 1'b0; addr = 12'h000;
    step(1); chk("rstwait_ovl_rom", 7'b1010001);
    nas = 1'b1;
    step(1); chk("rstwait_end", 7'b1110001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
